// File: rtl/cayde_decode_stage.sv
// cayde_decode_stage: registered RV32 OP/OP-IMM/LOAD/STORE decoder behind a 2-entry skid buffer.
package cayde_pkg;
  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op;
  typedef enum logic [2:0] {
    LOAD_NONE, LOAD_BYTE, LOAD_HALF_WORD, LOAD_WORD, LOAD_BYTE_UNSIGNED, LOAD_HALF_WORD_UNSIGNED
  } load_op;
  typedef enum logic [1:0] {STORE_NONE, STORE_BYTE, STORE_HALF_WORD, STORE_WORD} store_op;
endpackage

module cayde_decode_stage
  import cayde_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RV32E = 0,
  parameter int ENABLE_SHIFT_SLT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic [31:0]      instr_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output alu_op            alu_op_out,
  output load_op           load_op_out,
  output store_op          store_op_out,
  output logic [4:0]       rs1_out,
  output logic [4:0]       rs2_out,
  output logic [4:0]       rd_out,
  output logic [XLEN-1:0]  imm_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] illegal_cnt_out
);
  typedef struct packed {
    alu_op           alu;
    load_op          ld;
    store_op         st;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            bad;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          r_state;
  entry_t          r_main, r_skid;
  logic [CNT_W-1:0] r_cnt;
  entry_t          w_dec;
  logic [6:0]      w_f7;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_shamt;
  logic            w_acc, w_pop;

  assign w_f7    = instr_in[31:25];
  assign w_f3    = instr_in[14:12];
  assign w_imm_i = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
  assign w_imm_s = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign w_shamt = {{(XLEN-5){1'b0}}, instr_in[24:20]};

  always_comb begin
    w_dec     = '0;
    w_dec.rs1 = instr_in[19:15];
    w_dec.rd  = instr_in[11:7];
    case (instr_in[6:0])
      7'b0110011: begin
        w_dec.rs2 = instr_in[24:20];
        case ({w_f7, w_f3})
          10'h000: w_dec.alu = ALU_ADD;
          10'h001: w_dec.alu = ALU_SLL;
          10'h002: w_dec.alu = ALU_SLT;
          10'h003: w_dec.alu = ALU_SLTU;
          10'h004: w_dec.alu = ALU_XOR;
          10'h005: w_dec.alu = ALU_SRL;
          10'h006: w_dec.alu = ALU_OR;
          10'h007: w_dec.alu = ALU_AND;
          10'h100: w_dec.alu = ALU_SUB;
          10'h105: w_dec.alu = ALU_SRA;
          default: w_dec.bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_dec.imm = w_imm_i;
        case (w_f3)
          3'd0: w_dec.alu = ALU_ADD;
          3'd1: begin
            w_dec.alu = ALU_SLL;
            w_dec.imm = w_shamt;
            w_dec.bad = w_f7 != 7'h00;
          end
          3'd2: w_dec.alu = ALU_SLT;
          3'd3: w_dec.alu = ALU_SLTU;
          3'd4: w_dec.alu = ALU_XOR;
          3'd5: begin
            w_dec.alu = w_f7[5] ? ALU_SRA : ALU_SRL;
            w_dec.imm = w_shamt;
            w_dec.bad = w_f7 != 7'h00 && w_f7 != 7'h20;
          end
          3'd6: w_dec.alu = ALU_OR;
          default: w_dec.alu = ALU_AND;
        endcase
      end
      7'b0000011: begin
        w_dec.alu = ALU_ADD;
        w_dec.imm = w_imm_i;
        case (w_f3)
          3'd0: w_dec.ld = LOAD_BYTE;
          3'd1: w_dec.ld = LOAD_HALF_WORD;
          3'd2: w_dec.ld = LOAD_WORD;
          3'd4: w_dec.ld = LOAD_BYTE_UNSIGNED;
          3'd5: w_dec.ld = LOAD_HALF_WORD_UNSIGNED;
          default: w_dec.bad = 1'b1;
        endcase
      end
      7'b0100011: begin
        w_dec.alu = ALU_ADD;
        w_dec.imm = w_imm_s;
        w_dec.rs2 = instr_in[24:20];
        w_dec.rd  = 5'd0;
        case (w_f3)
          3'd0: w_dec.st = STORE_BYTE;
          3'd1: w_dec.st = STORE_HALF_WORD;
          3'd2: w_dec.st = STORE_WORD;
          default: w_dec.bad = 1'b1;
        endcase
      end
      default: w_dec.bad = 1'b1;
    endcase
    if (ENABLE_SHIFT_SLT == 0 && w_dec.alu inside {ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU})
      w_dec.bad = 1'b1;
    // unused rs2 and store rd are already zero, so only live indices are tested
    if (RV32E != 0 && (w_dec.rs1[4] | w_dec.rs2[4] | w_dec.rd[4]))
      w_dec.bad = 1'b1;
    if (w_dec.bad) begin
      w_dec     = '0;
      w_dec.bad = 1'b1;
    end
  end

  assign in_ready_out  = r_state != TWO;
  assign out_valid_out = r_state != EMPTY;
  assign w_acc = in_valid_in & in_ready_out;
  assign w_pop = out_valid_out & out_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_acc && w_dec.bad && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
      if (flush_in)
        r_state <= EMPTY;
      else
        case (r_state)
          EMPTY: if (w_acc) begin
            r_main  <= w_dec;
            r_state <= ONE;
          end
          ONE: if (w_acc && w_pop)
            r_main <= w_dec;
          else if (w_acc) begin
            r_skid  <= w_dec;
            r_state <= TWO;
          end else if (w_pop)
            r_state <= EMPTY;
          TWO: if (w_pop) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
          default: r_state <= EMPTY;
        endcase
    end
  end

  assign alu_op_out      = r_main.alu;
  assign load_op_out     = r_main.ld;
  assign store_op_out    = r_main.st;
  assign rs1_out         = r_main.rs1;
  assign rs2_out         = r_main.rs2;
  assign rd_out          = r_main.rd;
  assign imm_out         = r_main.imm;
  assign illegal_out     = r_main.bad;
  assign illegal_cnt_out = r_cnt;
endmodule
